trace_cmd_queue: RTL

TRACE_CMD_QUEUE -- requirements
Module: trace_cmd_queue

---
 rtl/mypkg.sv | 32 +++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/trace_cmd_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mypkg.sv
// Shared constants and types for the trace command queue: address field
// geometry, trace command encodings and the queue run-state encoding.
package mypkg;

    localparam int OFFSET_BITS = 6;
    localparam int INDEX_BITS  = 7;

    typedef enum logic [3:0] {
        CMD_RD  = 4'd0,
        CMD_WR  = 4'd1,
        CMD_IF  = 4'd2,
        CMD_INV = 4'd3,
        CMD_SNP = 4'd4,
        CMD_CLR = 4'd8,
        CMD_PRT = 4'd9
    } cmd_e;

    typedef enum logic [1:0] {
        Q_IDLE  = 2'd0,
        Q_RUN   = 2'd1,
        Q_DRAIN = 2'd2,
        Q_DONE  = 2'd3
    } q_state_e;

    function automatic logic cmd_is_legal(input logic [3:0] cmd);
        case (cmd)
            CMD_RD, CMD_WR, CMD_IF, CMD_INV, CMD_SNP, CMD_CLR, CMD_PRT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with count-based full/empty; the head entry is presented
// combinationally so a word written on one edge is visible right after it.
module cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/trace_cmd_queue.sv
// Trace record front end: accepts trace commands during a run, queues the
// legal ones for the cache model with the address split into fields, and keeps stats.
module trace_cmd_queue
    import mypkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = OFFSET_BITS,
    parameter int IDX_W  = INDEX_BITS,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_eof,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_cmd,
    input  logic [ADDR_W-1:0]             in_addr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    out_cmd,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [ADDR_W-IDX_W-OFF_W-1:0] out_tag,
    output logic [IDX_W-1:0]              out_index,
    output logic [OFF_W-1:0]              out_offset,
    output logic [CNT_W-1:0]              rd_cnt,
    output logic [CNT_W-1:0]              wr_cnt,
    output logic [CNT_W-1:0]              if_cnt,
    output logic [CNT_W-1:0]              snp_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [1:0]                    state,
    output logic                          done
);

    q_state_e           r_state;
    logic               r_done;
    logic [CNT_W-1:0]   r_rd_cnt, r_wr_cnt, r_if_cnt, r_snp_cnt, r_err_cnt;
    logic               w_full, w_empty;
    logic               w_accept, w_legal, w_push, w_pop, w_enter_run;
    logic [ADDR_W+3:0]  w_rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready    = (r_state == Q_RUN) && !w_full;
    assign w_accept    = in_valid && in_ready;
    assign w_legal     = cmd_is_legal(in_cmd);
    assign w_push      = w_accept && w_legal;
    assign w_pop       = !w_empty && out_ready;
    assign w_enter_run = start && ((r_state == Q_IDLE) || (r_state == Q_DONE));

    cmd_fifo #(
        .WIDTH (ADDR_W + 4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({in_cmd, in_addr}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid  = !w_empty;
    assign out_cmd    = w_rdata[ADDR_W+3:ADDR_W];
    assign out_addr   = w_rdata[ADDR_W-1:0];
    assign out_tag    = out_addr[ADDR_W-1:IDX_W+OFF_W];
    assign out_index  = out_addr[IDX_W+OFF_W-1:OFF_W];
    assign out_offset = out_addr[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= Q_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                Q_IDLE:  if (start)  r_state <= Q_RUN;
                Q_RUN:   if (in_eof) r_state <= Q_DRAIN;
                Q_DRAIN: if (w_empty) begin
                    r_state <= Q_DONE;
                    r_done  <= 1'b1;
                end
                Q_DONE:  if (start) begin
                    r_state <= Q_RUN;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= Q_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Accepts only happen in RUN, so clearing on run entry never races a count.
    always_ff @(posedge clk) begin
        if (!rst_n || w_enter_run) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_if_cnt  <= '0;
            r_snp_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            if (!w_legal) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end else begin
                case (in_cmd)
                    CMD_RD:           r_rd_cnt  <= sat_inc(r_rd_cnt);
                    CMD_WR:           r_wr_cnt  <= sat_inc(r_wr_cnt);
                    CMD_IF:           r_if_cnt  <= sat_inc(r_if_cnt);
                    CMD_INV, CMD_SNP: r_snp_cnt <= sat_inc(r_snp_cnt);
                    default: ;
                endcase
            end
        end
    end

    assign rd_cnt  = r_rd_cnt;
    assign wr_cnt  = r_wr_cnt;
    assign if_cnt  = r_if_cnt;
    assign snp_cnt = r_snp_cnt;
    assign err_cnt = r_err_cnt;
    assign state   = r_state;
    assign done    = r_done;

endmodule
